// File: rtl/axis2ccd.sv
// AXI4-Stream to CCD line timing; ping-pong line banks, fixed PRE/EFFECT/POST window plus GAP.
// Latency: tvalid rises 3 cycles after the closing pixel when the reader is idle; outputs registered.
// Backpressure: s_axis_tready drops only while the current write bank is still full. Option: AXIS2CCD_ERR_CNT_EN.
module axis2ccd #(
    parameter int                    DATA_WIDTH      = 8,
    parameter int                    EFFECT_COLS     = 2048,
    parameter int                    PRE_DUMMY_COLS  = 32,
    parameter int                    POST_DUMMY_COLS = 8,
    parameter int                    GAP_COLS        = 16,
    parameter logic [DATA_WIDTH-1:0] DUMMY_VALUE     = '0
) (
    input  logic                  pixel_clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_axis_tdata,
    input  logic                  s_axis_tvalid,
    input  logic                  s_axis_tuser,
    input  logic                  s_axis_tlast,
    output logic                  s_axis_tready,
    output logic                  tvalid,
    output logic [DATA_WIDTH-1:0] tdata,
    output logic                  frame_start,
`ifdef AXIS2CCD_ERR_CNT_EN
    output logic [15:0]           err_count,
`endif
    output logic                  line_err
);

    localparam int          CW        = (EFFECT_COLS > 1) ? $clog2(EFFECT_COLS) : 1;
    localparam logic [12:0] EFF_LAST  = 13'(EFFECT_COLS - 1);
    localparam logic [12:0] PRE_LAST  = 13'(PRE_DUMMY_COLS - 1);
    localparam logic [12:0] POST_LAST = 13'(POST_DUMMY_COLS - 1);
    localparam logic [12:0] GAP_LAST  = 13'(GAP_COLS - 1);

    typedef enum logic [2:0] {S_IDLE, S_PRE, S_EFFECT, S_POST, S_GAP} state_t;

    logic [DATA_WIDTH-1:0] mem_q [2][EFFECT_COLS];
    logic [DATA_WIDTH-1:0] rd_dat_q;

    logic             wr_bank_q, wr_bank_d;
    logic [12:0]      wr_col_q, wr_col_d;
    logic [1:0]       full_q, full_d;
    logic [1:0]       bank_fs_q, bank_fs_d;
    logic [1:0][12:0] bank_len_q, bank_len_d;
    logic             line_fs_q, line_fs_d;
    logic             drop_q, drop_d;
    logic             err_d, line_err_q;
    logic             tready_q;

    state_t           state_q, state_d;
    logic [12:0]      cnt_q, cnt_d;
    logic             rd_bank_q, rd_bank_d;
    logic             rd_clr;
    logic             tvalid_q, frame_start_q;
    logic [DATA_WIDTH-1:0] tdata_q;

    logic             accept, wr_en, col_fs;
    logic [12:0]      wr_addr_col;
    logic [CW-1:0]    rd_col;

    assign accept = s_axis_tvalid & tready_q;

    // Write side: a tuser mid-line restarts the same bank at column 0.
    always_comb begin
        wr_bank_d   = wr_bank_q;
        wr_col_d    = wr_col_q;
        full_d      = full_q;
        bank_fs_d   = bank_fs_q;
        bank_len_d  = bank_len_q;
        line_fs_d   = line_fs_q;
        drop_d      = drop_q;
        err_d       = 1'b0;
        wr_en       = 1'b0;
        wr_addr_col = wr_col_q;
        col_fs      = line_fs_q;
        if (rd_clr) begin
            full_d[rd_bank_q] = 1'b0;
        end
        if (accept) begin
            if (drop_q) begin
                if (s_axis_tlast) begin
                    drop_d = 1'b0;
                end
            end else begin
                if (s_axis_tuser && (wr_col_q != 13'd0)) begin
                    err_d       = 1'b1;
                    wr_addr_col = 13'd0;
                end
                if (wr_addr_col == 13'd0) begin
                    col_fs = s_axis_tuser;
                end
                wr_en = 1'b1;
                if (s_axis_tlast || (wr_addr_col == EFF_LAST)) begin
                    full_d[wr_bank_q]     = 1'b1;
                    bank_fs_d[wr_bank_q]  = col_fs;
                    bank_len_d[wr_bank_q] = wr_addr_col + 13'd1;
                    wr_bank_d             = ~wr_bank_q;
                    wr_col_d              = 13'd0;
                    line_fs_d             = 1'b0;
                    if (!s_axis_tlast) begin
                        err_d  = 1'b1;
                        drop_d = 1'b1;
                    end else if (wr_addr_col != EFF_LAST) begin
                        err_d = 1'b1;
                    end
                end else begin
                    wr_col_d  = wr_addr_col + 13'd1;
                    line_fs_d = col_fs;
                end
            end
        end
    end

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rd_bank_d = rd_bank_q;
        rd_clr    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (full_q[rd_bank_q]) begin
                    state_d = S_PRE;
                    cnt_d   = 13'd0;
                end
            end
            S_PRE: begin
                if (cnt_q == PRE_LAST) begin
                    state_d = S_EFFECT;
                    cnt_d   = 13'd0;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            S_EFFECT: begin
                if (cnt_q == EFF_LAST) begin
                    state_d   = S_POST;
                    cnt_d     = 13'd0;
                    rd_clr    = 1'b1;
                    rd_bank_d = ~rd_bank_q;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            S_POST: begin
                if (cnt_q == POST_LAST) begin
                    state_d = S_GAP;
                    cnt_d   = 13'd0;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            S_GAP: begin
                // Skip IDLE when the other bank is ready so the gap is exactly GAP_COLS.
                if (cnt_q == GAP_LAST) begin
                    state_d = full_q[rd_bank_q] ? S_PRE : S_IDLE;
                    cnt_d   = 13'd0;
                end else begin
                    cnt_d = cnt_q + 13'd1;
                end
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = 13'd0;
            end
        endcase
    end

    // Address from next state so read data lands together with the EFFECT column.
    assign rd_col = (state_d == S_EFFECT) ? cnt_d[CW-1:0] : '0;

    always_ff @(posedge pixel_clk) begin
        if (wr_en) begin
            mem_q[wr_bank_q][wr_addr_col[CW-1:0]] <= s_axis_tdata;
        end
        rd_dat_q <= mem_q[rd_bank_d][rd_col];
    end

    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            wr_bank_q     <= 1'b0;
            wr_col_q      <= 13'd0;
            full_q        <= 2'b00;
            bank_fs_q     <= 2'b00;
            bank_len_q    <= '0;
            line_fs_q     <= 1'b0;
            drop_q        <= 1'b0;
            line_err_q    <= 1'b0;
            tready_q      <= 1'b0;
            state_q       <= S_IDLE;
            cnt_q         <= 13'd0;
            rd_bank_q     <= 1'b0;
            tvalid_q      <= 1'b0;
            tdata_q       <= '0;
            frame_start_q <= 1'b0;
        end else begin
            wr_bank_q     <= wr_bank_d;
            wr_col_q      <= wr_col_d;
            full_q        <= full_d;
            bank_fs_q     <= bank_fs_d;
            bank_len_q    <= bank_len_d;
            line_fs_q     <= line_fs_d;
            drop_q        <= drop_d;
            line_err_q    <= err_d;
            tready_q      <= ~full_d[wr_bank_d];
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            rd_bank_q     <= rd_bank_d;
            tvalid_q      <= (state_q == S_PRE) || (state_q == S_EFFECT) || (state_q == S_POST);
            tdata_q       <= ((state_q == S_EFFECT) && (cnt_q < bank_len_q[rd_bank_q])) ?
                             rd_dat_q : DUMMY_VALUE;
            frame_start_q <= (state_q == S_EFFECT) && (cnt_q == 13'd0) && bank_fs_q[rd_bank_q];
        end
    end

`ifdef AXIS2CCD_ERR_CNT_EN
    logic [15:0] err_cnt_q;
    always_ff @(posedge pixel_clk) begin
        if (rst) begin
            err_cnt_q <= 16'd0;
        end else if (err_d && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_q <= err_cnt_q + 16'd1;
        end
    end
    assign err_count = err_cnt_q;
`endif

    assign s_axis_tready = tready_q;
    assign tvalid        = tvalid_q;
    assign tdata         = tdata_q;
    assign frame_start   = frame_start_q;
    assign line_err      = line_err_q;

endmodule

// File: tb/tb_axis2ccd.sv
// Self-checking bench for axis2ccd: directed vector table, back-to-back, random lines and reset mid-window.
module tb_axis2ccd;

    localparam int DW   = 8;
    localparam int EC   = 8;
    localparam int PRE  = 2;
    localparam int POST = 1;
    localparam int GAP  = 2;
    localparam int WIN  = PRE + EC + POST;

    logic          pixel_clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] s_axis_tdata = '0;
    logic          s_axis_tvalid = 1'b0;
    logic          s_axis_tuser = 1'b0;
    logic          s_axis_tlast = 1'b0;
    logic          s_axis_tready;
    logic          tvalid;
    logic [DW-1:0] tdata;
    logic          frame_start;
    logic          line_err;
`ifdef AXIS2CCD_ERR_CNT_EN
    logic [15:0]   err_count;
`endif

    axis2ccd #(
        .DATA_WIDTH(DW), .EFFECT_COLS(EC), .PRE_DUMMY_COLS(PRE),
        .POST_DUMMY_COLS(POST), .GAP_COLS(GAP), .DUMMY_VALUE(8'h00)
    ) dut (
        .pixel_clk(pixel_clk), .rst(rst),
        .s_axis_tdata(s_axis_tdata), .s_axis_tvalid(s_axis_tvalid),
        .s_axis_tuser(s_axis_tuser), .s_axis_tlast(s_axis_tlast),
        .s_axis_tready(s_axis_tready),
        .tvalid(tvalid), .tdata(tdata), .frame_start(frame_start),
`ifdef AXIS2CCD_ERR_CNT_EN
        .err_count(err_count),
`endif
        .line_err(line_err)
    );

    always #5 pixel_clk = ~pixel_clk;

    typedef struct { logic [7:0] data; logic user; logic last; } beat_t;
    typedef struct { int len; logic [15:0][7:0] d; int fs_idx; int fs_cnt; int gap; int rise; } win_t;
    typedef struct { logic [7:0][7:0] eff; bit fs; } exp_line_t;
    typedef struct { int npix; int user_col; int base; int exp_first; int exp_len; int exp_err; bit exp_fs; } vec_t;

    int        checks = 0;
    int        errors = 0;
    int        cyc = 0;
    win_t      wins[$];
    win_t      cur;
    bit        in_win = 1'b0;
    int        gap_run = -1;
    int        err_seen = 0;
    int        stray_fs = 0;
    int        last_acc_cyc = 0;
    beat_t     tx_q[$];
    beat_t     mdl_q[$];
    exp_line_t exp_q[$];
    int        exp_err;

    initial forever begin
        @(posedge pixel_clk);
        cyc++;
    end

    // Output monitor: collects each tvalid window and the low gap preceding it.
    initial forever begin
        @(negedge pixel_clk);
        if (rst) begin
            in_win  = 1'b0;
            gap_run = -1;
        end else begin
            if (line_err) err_seen++;
            if (tvalid) begin
                if (!in_win) begin
                    in_win     = 1'b1;
                    cur.len    = 0;
                    cur.d      = '0;
                    cur.fs_idx = -1;
                    cur.fs_cnt = 0;
                    cur.gap    = gap_run;
                    cur.rise   = cyc;
                end
                if (cur.len < 16) cur.d[cur.len] = tdata;
                if (frame_start) begin
                    cur.fs_cnt++;
                    if (cur.fs_idx < 0) cur.fs_idx = cur.len;
                end
                cur.len++;
            end else begin
                if (frame_start) stray_fs++;
                if (in_win) begin
                    wins.push_back(cur);
                    in_win  = 1'b0;
                    gap_run = 0;
                end
                if (gap_run >= 0) gap_run++;
            end
        end
    end

    task automatic check(input string name, input int got, input int exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d, expected %0d", name, got, exp);
        end
    endtask

    task automatic check_le(input string name, input int got, input int lim);
        checks++;
        if (got > lim) begin
            errors++;
            $display("FAIL %s: got %0d, expected at most %0d", name, got, lim);
        end
    endtask

    task automatic compare_win(input string tag, input win_t w, input logic [7:0][7:0] eff, input bit fs);
        int e;
        check({tag, " len"}, w.len, WIN);
        for (int i = 0; i < WIN; i++) begin
            e = (i >= PRE && i < PRE + EC) ? int'(eff[i-PRE]) : 0;
            check($sformatf("%s px%0d", tag, i), int'(w.d[i]), e);
        end
        check({tag, " fs_idx"}, w.fs_idx, fs ? PRE : -1);
        check({tag, " fs_cnt"}, w.fs_cnt, fs ? 1 : 0);
    endtask

    task automatic wait_wins(input int n, input string tag);
        int k = 0;
        while (wins.size() < n && k < 3000) begin
            @(negedge pixel_clk);
            k++;
        end
        if (wins.size() < n) begin
            checks++;
            errors++;
            $display("FAIL %s timeout: windows %0d, expected %0d", tag, wins.size(), n);
        end
        repeat (6) @(negedge pixel_clk);
    endtask

    task automatic drive_all(input int idle_pct);
        beat_t b;
        int    n;
        while (tx_q.size() > 0) begin
            b = tx_q.pop_front();
            if (idle_pct > 0 && int'($urandom_range(99)) < idle_pct) begin
                s_axis_tvalid = 1'b0;
                @(negedge pixel_clk);
            end
            s_axis_tdata  = b.data;
            s_axis_tuser  = b.user;
            s_axis_tlast  = b.last;
            s_axis_tvalid = 1'b1;
            n = 0;
            while (!s_axis_tready && n < 2000) begin
                @(negedge pixel_clk);
                n++;
            end
            if (!s_axis_tready) begin
                checks++;
                errors++;
                $display("FAIL drive timeout: tready %0d, expected 1", s_axis_tready);
                tx_q.delete();
            end else begin
                last_acc_cyc = cyc;
            end
            @(negedge pixel_clk);
        end
        s_axis_tvalid = 1'b0;
        s_axis_tuser  = 1'b0;
        s_axis_tlast  = 1'b0;
    endtask

    // Reference: lines by rule over the beat list, one expected error per offending beat.
    task automatic model_run();
        logic [7:0] line[$];
        bit         fs = 1'b0;
        bit         drop = 1'b0;
        bit         e;
        exp_line_t  x;
        exp_q.delete();
        exp_err = 0;
        foreach (mdl_q[i]) begin
            e = 1'b0;
            if (drop) begin
                if (mdl_q[i].last) drop = 1'b0;
                continue;
            end
            if (mdl_q[i].user && line.size() > 0) begin
                e = 1'b1;
                line.delete();
            end
            if (line.size() == 0) fs = mdl_q[i].user;
            line.push_back(mdl_q[i].data);
            if (mdl_q[i].last || line.size() == EC) begin
                for (int k = 0; k < EC; k++) x.eff[k] = (k < line.size()) ? line[k] : 8'h00;
                x.fs = fs;
                exp_q.push_back(x);
                if (line.size() != EC || !mdl_q[i].last) e = 1'b1;
                if (!mdl_q[i].last) drop = 1'b1;
                line.delete();
            end
            if (e) exp_err++;
        end
    endtask

    task automatic push_line(input int npix, input int user_col, input int base);
        beat_t b;
        for (int p = 0; p < npix; p++) begin
            b.data = 8'(base + p);
            b.user = (p == user_col);
            b.last = (p == npix - 1);
            tx_q.push_back(b);
        end
    endtask

    initial begin
        vec_t            vt[6];
        int              n0, e0, nl, r, n, ucol;
        bit              fu;
        beat_t           b;
        logic [7:0][7:0] eff;

        vt[0] = '{8,  0,   1, 0, 8, 0, 1'b1};
        vt[1] = '{5,  0,  32, 0, 5, 1, 1'b1};
        vt[2] = '{10, 0,  64, 0, 8, 1, 1'b1};
        vt[3] = '{8, -1,  96, 0, 8, 0, 1'b0};
        vt[4] = '{11, 3, 128, 3, 8, 1, 1'b1};
        vt[5] = '{2, -1, 160, 0, 2, 1, 1'b0};

        repeat (3) @(negedge pixel_clk);
        check("reset tvalid", int'(tvalid), 0);
        check("reset tdata", int'(tdata), 0);
        check("reset frame_start", int'(frame_start), 0);
        check("reset line_err", int'(line_err), 0);
        check("reset tready", int'(s_axis_tready), 0);
`ifdef AXIS2CCD_ERR_CNT_EN
        check("reset err_count", int'(err_count), 0);
`endif
        rst = 1'b0;
        @(negedge pixel_clk);
        check("tready after reset", int'(s_axis_tready), 1);

        for (int i = 0; i < 6; i++) begin
            n0 = wins.size();
            e0 = err_seen;
            push_line(vt[i].npix, vt[i].user_col, vt[i].base);
            drive_all(0);
            wait_wins(n0 + 1, $sformatf("vec%0d", i));
            if (wins.size() > n0) begin
                for (int k = 0; k < EC; k++)
                    eff[k] = (k < vt[i].exp_len) ? 8'(vt[i].base + vt[i].exp_first + k) : 8'h00;
                compare_win($sformatf("vec%0d", i), wins[n0], eff, vt[i].exp_fs);
                check_le($sformatf("vec%0d latency", i), wins[n0].rise - last_acc_cyc, 3);
                if (wins[n0].gap >= 0) check_le($sformatf("vec%0d gap", i), GAP, wins[n0].gap);
            end
            check($sformatf("vec%0d line_err pulses", i), err_seen - e0, vt[i].exp_err);
        end

        // Back-to-back with continuous input: windows must be exactly GAP apart.
        n0 = wins.size();
        e0 = err_seen;
        for (int l = 0; l < 4; l++) push_line(EC, 0, 16 * (l + 1));
        drive_all(0);
        wait_wins(n0 + 4, "b2b");
        for (int l = 0; l < 4; l++) begin
            if (wins.size() > n0 + l) begin
                for (int k = 0; k < EC; k++) eff[k] = 8'(16 * (l + 1) + k);
                compare_win($sformatf("b2b%0d", l), wins[n0+l], eff, 1'b1);
                if (l > 0) check($sformatf("b2b%0d gap", l), wins[n0+l].gap, GAP);
            end
        end
        check("b2b line_err pulses", err_seen - e0, 0);

        // Random lines: normal, short, long, mid-line tuser, with idle cycles.
        n0 = wins.size();
        e0 = err_seen;
        mdl_q.delete();
        for (int l = 0; l < 25; l++) begin
            r = int'($urandom_range(9));
            n = (r < 6) ? EC : ((r < 8) ? int'($urandom_range(1, EC - 1)) : int'($urandom_range(EC + 1, EC + 4)));
            ucol = (n > 1 && $urandom_range(9) < 2) ? int'($urandom_range(1, n - 1)) : -1;
            fu = 1'($urandom_range(1));
            for (int p = 0; p < n; p++) begin
                b.data = 8'($urandom);
                b.user = (p == 0 && fu) || (p == ucol);
                b.last = (p == n - 1);
                tx_q.push_back(b);
                mdl_q.push_back(b);
            end
        end
        model_run();
        nl = exp_q.size();
        drive_all(30);
        wait_wins(n0 + nl, "rand");
        check("rand window count", wins.size() - n0, nl);
        for (int l = 0; l < nl; l++) begin
            if (wins.size() > n0 + l) begin
                compare_win($sformatf("rand%0d", l), wins[n0+l], exp_q[l].eff, exp_q[l].fs);
                if (wins[n0+l].gap >= 0) check_le($sformatf("rand%0d gap", l), GAP, wins[n0+l].gap);
            end
        end
        check("rand line_err pulses", err_seen - e0, exp_err);
`ifdef AXIS2CCD_ERR_CNT_EN
        check("err_count total", int'(err_count), err_seen);
`endif

        // Reset in the middle of a window.
        n0 = wins.size();
        push_line(EC, 0, 192);
        drive_all(0);
        for (int k = 0; k < 200 && !(in_win && cur.len >= 4); k++) @(negedge pixel_clk);
        check("window open before reset", int'(in_win), 1);
        rst = 1'b1;
        @(negedge pixel_clk);
        check("tvalid after mid reset", int'(tvalid), 0);
        check("line_err after mid reset", int'(line_err), 0);
`ifdef AXIS2CCD_ERR_CNT_EN
        check("err_count after mid reset", int'(err_count), 0);
`endif
        @(negedge pixel_clk);
        rst = 1'b0;
        @(negedge pixel_clk);
        check("tready after mid reset", int'(s_axis_tready), 1);
        check("no window from aborted line", wins.size() - n0, 0);
        e0 = err_seen;
        push_line(EC, 0, 224);
        drive_all(0);
        wait_wins(n0 + 1, "post-reset");
        if (wins.size() > n0) begin
            for (int k = 0; k < EC; k++) eff[k] = 8'(224 + k);
            compare_win("post-reset", wins[n0], eff, 1'b1);
            check_le("post-reset latency", wins[n0].rise - last_acc_cyc, 3);
        end
        check("post-reset line_err pulses", err_seen - e0, 0);
        check("frame_start outside window", stray_fs, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #500000;
        errors++;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
